// File: rtl/uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_pkg
// Shared definitions for the UART transmitter:
//   state_t        - frame sequencer states
//   *_LVL          - line levels for start / stop / idle
//   DATA_BITS      - payload width of one frame
//   reload_value() - bit-timer reload for a given clk_ratio (0 behaves as 1)
// Optional feature macro used by the core: UART_TX_PARITY_EN
// ---------------------------------------------------------------------------
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;
    localparam int   DATA_BITS = 8;

    // A bit lasts P cycles, so the down-counter starts at P-1 and the bit
    // ends on the cycle it reads zero. A ratio of 0 is treated as 1.
    function automatic logic [7:0] reload_value(input logic [7:0] ratio);
        return (ratio == 8'd0) ? 8'd0 : ratio - 8'd1;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// ---------------------------------------------------------------------------
// uart_bit_timer
// Loadable 8-bit down-counter that paces the serial bit periods.
// Ports:
//   clk        - clock
//   srst       - synchronous active-high reset (counter cleared)
//   load       - load load_value this cycle (takes priority over counting)
//   load_value - value loaded into the counter
//   tick       - high while the counter reads zero (last cycle of a bit)
// The counter holds at zero instead of wrapping.
// ---------------------------------------------------------------------------
module uart_bit_timer (
    input  logic       clk,
    input  logic       srst,
    input  logic       load,
    input  logic [7:0] load_value,
    output logic       tick
);

    logic [7:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= 8'd0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (count_reg != 8'd0) begin
            count_reg <= count_reg - 8'd1;
        end
    end

    assign tick = (count_reg == 8'd0);

endmodule

// File: rtl/uart_tx_core.sv
// ---------------------------------------------------------------------------
// uart_tx_core
// UART transmitter, 8 data bits LSB-first, 1 or 2 stop bits, optional parity.
// Bit period is clk_ratio clock cycles (0 behaves as 1), latched per frame.
// Ports:
//   clk        - clock, all logic on posedge
//   rst        - synchronous active-high reset, aborts any frame in flight
//   enable     - transmit request, only looked at while idle
//   data       - byte to send, captured when the request is accepted
//   clk_ratio  - clock cycles per bit, captured when the request is accepted
//   tx_active  - registered, high for the whole frame including stop bit(s)
//   tx         - registered serial output, idles high
// Parameters:
//   STOP_BITS  - 1 or 2 stop bits
//   PARITY_ODD - parity sense when parity is built in (0 even, 1 odd)
// Build option: define UART_TX_PARITY_EN to insert a parity bit after the
// data bits; without it there is no parity state or parity logic.
// ---------------------------------------------------------------------------
module uart_tx_core
    import uart_tx_pkg::*;
#(
    parameter int STOP_BITS  = 1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] data,
    input  logic [7:0] clk_ratio,
    output logic       tx_active,
    output logic       tx
);

    // Index of the final stop bit; anything other than 2 behaves as 1.
    localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    state_t     state_reg, state_next;
    logic [7:0] shreg_reg, shreg_next;
    logic [7:0] shreg_shifted;
    logic [2:0] bit_idx_reg, bit_idx_next;
    logic       stop_idx_reg, stop_idx_next;
    logic [7:0] period_reg, period_next;
    logic       tx_reg, tx_next;
    logic       tx_active_reg, tx_active_next;
`ifdef UART_TX_PARITY_EN
    logic [7:0] data_latched_reg, data_latched_next;
`endif

    logic       timer_load;
    logic [7:0] timer_value;
    logic       timer_tick;

    uart_bit_timer u_bit_timer (
        .clk        (clk),
        .srst       (rst),
        .load       (timer_load),
        .load_value (timer_value),
        .tick       (timer_tick)
    );

    // Shift-right view of the shift register, zero filled from the top.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_BITS; gi++) begin : g_shift
            if (gi == DATA_BITS - 1) begin : g_top
                assign shreg_shifted[gi] = 1'b0;
            end else begin : g_mid
                assign shreg_shifted[gi] = shreg_reg[gi + 1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            shreg_reg        <= 8'd0;
            bit_idx_reg      <= 3'd0;
            stop_idx_reg     <= 1'b0;
            period_reg       <= 8'd0;
            tx_reg           <= IDLE_LVL;
            tx_active_reg    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            data_latched_reg <= 8'd0;
`endif
        end else begin
            state_reg        <= state_next;
            shreg_reg        <= shreg_next;
            bit_idx_reg      <= bit_idx_next;
            stop_idx_reg     <= stop_idx_next;
            period_reg       <= period_next;
            tx_reg           <= tx_next;
            tx_active_reg    <= tx_active_next;
`ifdef UART_TX_PARITY_EN
            data_latched_reg <= data_latched_next;
`endif
        end
    end

    // Outputs are registered: tx_next / tx_active_next describe the line
    // level for the state being entered at this edge.
    always_comb begin
        state_next        = state_reg;
        shreg_next        = shreg_reg;
        bit_idx_next      = bit_idx_reg;
        stop_idx_next     = stop_idx_reg;
        period_next       = period_reg;
        tx_next           = tx_reg;
        tx_active_next    = tx_active_reg;
        timer_load        = 1'b0;
        timer_value       = reload_value(period_reg);
`ifdef UART_TX_PARITY_EN
        data_latched_next = data_latched_reg;
`endif

        case (state_reg)
            IDLE: begin
                tx_next        = IDLE_LVL;
                tx_active_next = 1'b0;
                if (enable) begin
                    state_next     = START;
                    shreg_next     = data;
                    period_next    = clk_ratio;
                    bit_idx_next   = 3'd0;
                    stop_idx_next  = 1'b0;
                    // period_reg is not yet valid, so reload from the port.
                    timer_load     = 1'b1;
                    timer_value    = reload_value(clk_ratio);
                    tx_next        = START_LVL;
                    tx_active_next = 1'b1;
`ifdef UART_TX_PARITY_EN
                    data_latched_next = data;
`endif
                end
            end

            START: begin
                if (timer_tick) begin
                    state_next   = DATA;
                    timer_load   = 1'b1;
                    bit_idx_next = 3'd0;
                    tx_next      = shreg_reg[0];
                    shreg_next   = shreg_shifted;
                end
            end

            DATA: begin
                if (timer_tick) begin
                    timer_load = 1'b1;
                    if (bit_idx_reg == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
                        tx_next    = (^data_latched_reg) ^ PARITY_ODD;
`else
                        state_next    = STOP;
                        stop_idx_next = 1'b0;
                        tx_next       = STOP_LVL;
`endif
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                        tx_next      = shreg_reg[0];
                        shreg_next   = shreg_shifted;
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (timer_tick) begin
                    state_next    = STOP;
                    stop_idx_next = 1'b0;
                    timer_load    = 1'b1;
                    tx_next       = STOP_LVL;
                end
            end
`endif

            STOP: begin
                if (timer_tick) begin
                    if (stop_idx_reg == STOP_LAST) begin
                        state_next     = IDLE;
                        tx_next        = IDLE_LVL;
                        tx_active_next = 1'b0;
                    end else begin
                        stop_idx_next = 1'b1;
                        timer_load    = 1'b1;
                    end
                end
            end

            default: begin
                state_next     = IDLE;
                tx_next        = IDLE_LVL;
                tx_active_next = 1'b0;
            end
        endcase
    end

    assign tx        = tx_reg;
    assign tx_active = tx_active_reg;

endmodule

// File: tb/tb_uart_tx_core.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_core
// Directed bench for uart_tx_core (STOP_BITS=1). When UART_TX_PARITY_EN is
// defined, a second instance with PARITY_ODD=1 shares the inputs so both
// parity senses are exercised by the same frame.
// ---------------------------------------------------------------------------
module tb_uart_tx_core;

    localparam int STOP_BITS_TB = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_SLOTS = 1;
`else
    localparam int PAR_SLOTS = 0;
`endif
    localparam int FRAME_SLOTS = 10 + (STOP_BITS_TB - 1) + PAR_SLOTS;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] data;
    logic [7:0] clk_ratio;
    logic       tx_active;
    logic       tx;

    int n_checks = 0;
    int n_pass   = 0;

    logic txq[$];
`ifdef UART_TX_PARITY_EN
    logic tx_odd;
    logic tx_active_odd;
    logic txq_odd[$];
`endif

    always #5 clk = ~clk;

    uart_tx_core #(.STOP_BITS(STOP_BITS_TB), .PARITY_ODD(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .data      (data),
        .clk_ratio (clk_ratio),
        .tx_active (tx_active),
        .tx        (tx)
    );

`ifdef UART_TX_PARITY_EN
    uart_tx_core #(.STOP_BITS(STOP_BITS_TB), .PARITY_ODD(1'b1)) dut_odd (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .data      (data),
        .clk_ratio (clk_ratio),
        .tx_active (tx_active_odd),
        .tx        (tx_odd)
    );
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Expected line level in bit slot k of an even-parity frame.
    function automatic logic exp_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (PAR_SLOTS == 1 && k == 9) return ^d;
        return 1'b1;
    endfunction

    function automatic int eff_period(input logic [7:0] r);
        return (r == 8'd0) ? 1 : int'(r);
    endfunction

    // Request a frame from a falling edge; returns at the falling edge of
    // frame cycle 1, where start latency is checked.
    task automatic start_frame(input logic [7:0] d, input logic [7:0] r, input bit hold);
        data      = d;
        clk_ratio = r;
        enable    = 1'b1;
        @(negedge clk);
        if (!hold) enable = 1'b0;
        check("start_active", {31'd0, tx_active}, 32'd1);
    endtask

    // Record tx every cycle while tx_active is high; returns on the first
    // idle cycle.
    task automatic run_frame();
        int n;
        n = 0;
        txq.delete();
`ifdef UART_TX_PARITY_EN
        txq_odd.delete();
`endif
        while (tx_active === 1'b1 && n < 4000) begin
            txq.push_back(tx);
`ifdef UART_TX_PARITY_EN
            txq_odd.push_back(tx_odd);
`endif
            n++;
            @(negedge clk);
        end
        if (n >= 4000) check("frame_timeout", 32'd1, 32'd0);
    endtask

    task automatic compare_frame(input string tag, input logic [7:0] d, input logic [7:0] r);
        int p;
        int errs;
        logic [7:0] dec;
        p = eff_period(r);
        check({tag, "_len"}, txq.size(), FRAME_SLOTS * p);
        errs = 0;
        for (int i = 0; i < txq.size(); i++) begin
            if (txq[i] !== exp_bit(d, i / p)) errs++;
        end
        check({tag, "_wave_errs"}, errs, 0);
        dec = 8'd0;
        for (int i = 0; i < 8; i++) begin
            if ((i + 1) * p + p / 2 < txq.size()) dec[i] = txq[(i + 1) * p + p / 2];
        end
        check({tag, "_byte"}, {24'd0, dec}, {24'd0, d});
        check({tag, "_idle_tx"}, {31'd0, tx}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b2b [3];
        b2b[0] = 8'h55;
        b2b[1] = 8'h99;
        b2b[2] = 8'hED;

        rst       = 1'b1;
        enable    = 1'b0;
        data      = 8'h00;
        clk_ratio = 8'd1;
        repeat (3) @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_active", {31'd0, tx_active}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 100-cycle bits, byte 0x01
        start_frame(8'h01, 8'h64, 1'b0);
        run_frame();
        check("p100_c1", {31'd0, txq[0]}, 32'd0);
        check("p100_c100", {31'd0, txq[99]}, 32'd0);
        check("p100_c101", {31'd0, txq[100]}, 32'd1);
        check("p100_c200", {31'd0, txq[199]}, 32'd1);
        check("p100_c201", {31'd0, txq[200]}, 32'd0);
        check("p100_c900", {31'd0, txq[899]}, 32'd0);
        compare_frame("p100", 8'h01, 8'h64);

        // back-to-back bytes, one idle cycle between frames
        for (int i = 0; i < 3; i++) begin
            start_frame(b2b[i], 8'd4, 1'b0);
            run_frame();
            compare_frame("b2b", b2b[i], 8'd4);
        end

        // enable held across the frame end; data changed mid-frame
        start_frame(8'h3C, 8'd2, 1'b1);
        data = 8'hFF;
        run_frame();
        compare_frame("hold_a", 8'h3C, 8'd2);
        check("hold_gap_active", {31'd0, tx_active}, 32'd0);
        @(negedge clk);
        check("hold_restart", {31'd0, tx_active}, 32'd1);
        enable = 1'b0;
        run_frame();
        compare_frame("hold_b", 8'hFF, 8'd2);

        // ratio 0 and 1 both give 1-cycle bits
        start_frame(8'hA6, 8'd0, 1'b0);
        run_frame();
        compare_frame("r0", 8'hA6, 8'd0);
        start_frame(8'h6A, 8'd1, 1'b0);
        run_frame();
        compare_frame("r1", 8'h6A, 8'd1);

        // ratio changed mid-frame only affects the next frame
        start_frame(8'h5A, 8'd3, 1'b0);
        clk_ratio = 8'd7;
        run_frame();
        compare_frame("rchg_a", 8'h5A, 8'd3);
        start_frame(8'hC3, 8'd7, 1'b0);
        run_frame();
        compare_frame("rchg_b", 8'hC3, 8'd7);

        // reset during DATA aborts the frame
        start_frame(8'hF0, 8'd4, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_tx", {31'd0, tx}, 32'd1);
        check("abort_active", {31'd0, tx_active}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        start_frame(8'hA5, 8'd3, 1'b0);
        run_frame();
        compare_frame("after_rst", 8'hA5, 8'd3);

`ifdef UART_TX_PARITY_EN
        // 0x07 has three ones: even parity 1, odd parity 0
        start_frame(8'h07, 8'd4, 1'b0);
        run_frame();
        compare_frame("par", 8'h07, 8'd4);
        check("par_len44", txq.size(), 32'd44);
        check("par_even_bit", {31'd0, txq[38]}, 32'd1);
        check("par_odd_bit", {31'd0, txq_odd[38]}, 32'd0);
        check("par_odd_len", txq_odd.size(), 32'd44);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
